// File: rtl/blowfish_pkey_mixer.sv
// Blowfish P-array key mixer: loads a key word by word, then XORs ROM init constants with the cyclic key.
// Optional build macro BLOWFISH_KEY_ZEROIZE_EN wipes the key on completion of each mix.
module blowfish_pkey_mixer #(
    parameter int NUM_P         = 20,
    parameter int WORD_W        = 32,
    parameter int MAX_KEY_WORDS = 16
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [WORD_W-1:0]        key_word,
    input  logic                     key_last,
    input  logic                     Enable,
    input  logic                     Encrypt,
    output logic                     pinit_rd,
    output logic [$clog2(NUM_P)-1:0] pinit_addr,
    input  logic [WORD_W-1:0]        pinit_data,
    input  logic [$clog2(NUM_P)-1:0] skey_idx,
    output logic [WORD_W-1:0]        skey_data,
    output logic                     skey_ready,
    output logic                     busy,
    output logic                     error
);

    localparam int AW     = $clog2(NUM_P);
    localparam int KIW    = (MAX_KEY_WORDS > 1) ? $clog2(MAX_KEY_WORDS) : 1;
    localparam int KLW    = $clog2(MAX_KEY_WORDS + 1);
    localparam int KDEPTH = 1 << KIW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_key_ready;
    logic              r_busy;
    logic              r_error;
    logic              r_skey_ready;
    logic [WORD_W-1:0] r_skey_data;
    logic              r_pinit_rd;
    logic [AW-1:0]     r_pinit_addr;

    logic [WORD_W-1:0] r_p   [0:NUM_P-1];
    logic [WORD_W-1:0] r_key [0:KDEPTH-1];
    logic [KIW-1:0]    r_key_cnt;
    logic [KLW-1:0]    r_key_len;
    logic              r_key_loaded;

    logic              r_wr_en;
    logic [AW-1:0]     r_wr_idx;
    logic [KIW-1:0]    r_kidx;

    logic              w_key_hs;
    logic              w_cnt_last;
    logic              w_kidx_wrap;
    logic              w_idx_in_range;
    logic [AW-1:0]     w_rd_sel;

    always_comb begin
        w_key_hs       = key_valid & r_key_ready;
        w_cnt_last     = key_last | (r_key_cnt == KIW'(MAX_KEY_WORDS - 1));
        // Key index wraps at key_len, giving i mod key_len without a divider.
        w_kidx_wrap    = ((KLW'(r_kidx) + KLW'(1)) == r_key_len);
        w_idx_in_range = ({1'b0, skey_idx} < (AW + 1)'(NUM_P));
        w_rd_sel       = Encrypt ? skey_idx : (AW'(NUM_P - 1) - skey_idx);
    end

    // NOTE: all state below uses non-blocking assignments so every register sees
    // pre-edge values of the others, regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= IDLE;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
            r_skey_ready <= 1'b0;
            r_skey_data  <= '0;
            r_pinit_rd   <= 1'b0;
            r_pinit_addr <= '0;
            r_key_cnt    <= '0;
            r_key_len    <= '0;
            r_key_loaded <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_idx     <= '0;
            r_kidx       <= '0;
            // NOTE: the subkey and key arrays are reset explicitly so no stale key
            // material survives a reset; this keeps them in flops rather than RAM.
            for (int i = 0; i < NUM_P; i++) r_p[i] <= '0;
            for (int i = 0; i < KDEPTH; i++) r_key[i] <= '0;
        end else begin
            r_error     <= 1'b0;
            r_skey_data <= (r_skey_ready && w_idx_in_range) ? r_p[w_rd_sel] : '0;

            if (w_key_hs) begin
                r_key[r_key_cnt] <= key_word;
                r_key_loaded     <= w_cnt_last;
                if (w_cnt_last) begin
                    r_key_len <= KLW'(r_key_cnt) + KLW'(1);
                    r_key_cnt <= '0;
                end else begin
                    r_key_cnt <= r_key_cnt + KIW'(1);
                end
            end

            case (r_state)
                IDLE, DONE: begin
                    if (w_key_hs) begin
                        // A new key invalidates the current subkeys.
                        r_state      <= IDLE;
                        r_skey_ready <= 1'b0;
                        r_skey_data  <= '0;
                    end else if (Enable) begin
                        if (r_key_loaded) begin
                            r_state      <= MIX;
                            r_busy       <= 1'b1;
                            r_key_ready  <= 1'b0;
                            r_skey_ready <= 1'b0;
                            r_skey_data  <= '0;
                            r_pinit_rd   <= 1'b1;
                            r_pinit_addr <= '0;
                            r_wr_en      <= 1'b0;
                            r_wr_idx     <= '0;
                            r_kidx       <= '0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                MIX: begin
                    // ROM data lags the read strobe by one cycle.
                    r_wr_en <= r_pinit_rd;
                    if (r_pinit_rd) begin
                        if (r_pinit_addr == AW'(NUM_P - 1)) begin
                            r_pinit_rd   <= 1'b0;
                            r_pinit_addr <= '0;
                        end else begin
                            r_pinit_addr <= r_pinit_addr + AW'(1);
                        end
                    end

                    if (r_wr_en) begin
                        r_p[r_wr_idx] <= pinit_data ^ r_key[r_kidx];
                        r_wr_idx      <= r_wr_idx + AW'(1);
                        r_kidx        <= w_kidx_wrap ? '0 : (r_kidx + KIW'(1));
                        if (r_wr_idx == AW'(NUM_P - 1)) begin
                            r_state      <= DONE;
                            r_busy       <= 1'b0;
                            r_key_ready  <= 1'b1;
                            r_skey_ready <= 1'b1;
`ifdef BLOWFISH_KEY_ZEROIZE_EN
                            r_key_loaded <= 1'b0;
                            for (int i = 0; i < KDEPTH; i++) r_key[i] <= '0;
`else
                            r_key_loaded <= r_key_loaded;
`endif
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_key_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready  = r_key_ready;
    assign busy       = r_busy;
    assign error      = r_error;
    assign skey_ready = r_skey_ready;
    assign skey_data  = r_skey_data;
    assign pinit_rd   = r_pinit_rd;
    assign pinit_addr = r_pinit_addr;

endmodule
